// File: rtl/bus_mailbox_responder.sv
// rtl/bus_mailbox_responder.sv - bus-mapped mailbox with TX/RX stream FIFOs and RX interrupt
// Optional loopback path (CTRL[3]) is built only when MBOX_LOOPBACK_EN is defined.
module bus_mailbox_responder #(
  parameter int WAIT_CYCLES = 0,
  parameter int DEPTH       = 8,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              irq,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [3:0]    WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        op_write;
  logic [1:0]  op_reg;
  logic [31:0] op_wdata;
  logic        resp_pop_ok;
  logic        req, to_resp, cur_write;
  logic [1:0]  cur_reg;
  logic [31:0] rd_val, status_word;

  logic        rx_irq_en, loopback, tx_ovf, rx_unf;
  logic        wr_hit, rd_hit, ctrl_wr, w1c_wr;
  logic        tx_push_req, tx_push, tx_pop, tx_flush, tx_ovf_set;
  logic        rx_pop_req, rx_push, rx_pop, rx_flush, rx_unf_set, lb_xfer;
  logic [DATA_W-1:0] rx_push_data, tx_head, rx_head;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   tx_count, rx_count;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          unused_ok;

  assign req       = sel & (we | re);
  assign cur_write = (state == ST_IDLE) ? we : op_write;
  assign cur_reg   = (state == ST_IDLE) ? addr[3:2] : op_reg;
  assign to_resp   = (state_nxt == ST_RESP) && (state != ST_RESP);
  assign ready     = (state == ST_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd1) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_TURN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read data is captured on entry to RESP; resp_pop_ok records whether that
  // snapshot came from a real RX entry so the pop stays consistent with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      op_write    <= 1'b0;
      op_reg      <= 2'd0;
      op_wdata    <= 32'd0;
      rdata       <= 32'd0;
      resp_pop_ok <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req) begin
        op_write <= we;
        op_reg   <= addr[3:2];
        op_wdata <= wdata;
        wait_cnt <= WAIT_INIT;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (to_resp) begin
        rdata       <= rd_val;
        resp_pop_ok <= !rx_empty;
      end else begin
        rdata <= 32'd0;
      end
    end
  end

  assign status_word = {8'h00, 8'(rx_count), 8'(tx_count), 2'b00,
                        rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rd_val = 32'd0;
    if (!cur_write) begin
      case (cur_reg)
        2'd0: if (!rx_empty) rd_val[DATA_W-1:0] = rx_head;
        2'd1: rd_val = status_word;
        2'd2: begin
          rd_val[0] = rx_irq_en;
          rd_val[3] = loopback;
        end
        default: rd_val = 32'd0;
      endcase
    end
  end

  assign wr_hit      = (state == ST_RESP) & op_write;
  assign rd_hit      = (state == ST_RESP) & !op_write;
  assign ctrl_wr     = wr_hit & (op_reg == 2'd2);
  assign w1c_wr      = wr_hit & (op_reg == 2'd1);
  assign tx_push_req = wr_hit & (op_reg == 2'd0);
  assign tx_push     = tx_push_req & !tx_full;
  assign tx_ovf_set  = tx_push_req & tx_full;
  assign tx_flush    = ctrl_wr & op_wdata[1];
  assign rx_flush    = ctrl_wr & op_wdata[2];
  assign rx_pop_req  = rd_hit & (op_reg == 2'd0);
  assign rx_pop      = rx_pop_req & resp_pop_ok;
  assign rx_unf_set  = rx_pop_req & !resp_pop_ok;

  assign tx_full  = (tx_count == CNT_FULL);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CNT_FULL);
  assign rx_empty = (rx_count == '0);
  assign tx_head  = tx_mem[tx_rd_ptr];
  assign rx_head  = rx_mem[rx_rd_ptr];

  assign lb_xfer      = loopback & !tx_empty & !rx_full;
  assign tx_valid     = !tx_empty & !loopback;
  assign tx_data      = tx_head;
  assign rx_ready     = !rx_full & !loopback;
  assign tx_pop       = loopback ? lb_xfer : (tx_valid & tx_ready);
  assign rx_push      = loopback ? lb_xfer : (rx_valid & rx_ready);
  assign rx_push_data = loopback ? tx_head : rx_data;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= op_wdata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
  end

  // Flush overrides any push or pop landing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_irq_en <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (ctrl_wr) rx_irq_en <= op_wdata[0];
      tx_ovf <= tx_ovf_set | (tx_ovf & !(w1c_wr & op_wdata[4]));
      rx_unf <= rx_unf_set | (rx_unf & !(w1c_wr & op_wdata[5]));
      irq    <= rx_irq_en & !rx_empty;
    end
  end

`ifdef MBOX_LOOPBACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       loopback <= 1'b0;
    else if (ctrl_wr) loopback <= op_wdata[3];
  end
`else
  assign loopback = 1'b0;
`endif

  assign unused_ok = &{1'b0, addr, wdata, op_wdata};

endmodule

// File: tb/tb_bus_mailbox_responder.sv
// tb/tb_bus_mailbox_responder.sv - directed self-checking bench for bus_mailbox_responder
module tb_bus_mailbox_responder;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] rd;
  int          lat;
  logic        rx_ready_at_resp;

  bus_mailbox_responder #(.WAIT_CYCLES(WAIT), .DEPTH(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata), .ready(ready), .irq(irq),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Returns in the TURN cycle following the response.
  task automatic bus_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] data, output int cycles);
    @(posedge clk); #1;
    sel = 1'b1; we = wr; re = !wr; addr = a; wdata = d;
    cycles = 0;
    data = '0;
    while (cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
      if (ready) break;
    end
    if (!ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL bus_timeout: addr 0x%08h got no ready expected ready", a);
    end else begin
      data = rdata;
      rx_ready_at_resp = rx_ready;
    end
    sel = 1'b0; we = 1'b0; re = 1'b0; rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    int c;
    bus_xfer(1'b1, a, d, dummy, c);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] data);
    int c;
    bus_xfer(1'b0, a, 32'd0, data, c);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_rx_ready", {31'd0, rx_ready}, 32'd1);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h77;
    @(posedge clk); #1;
    seen |= ready;
    @(posedge clk); #1;
    seen |= ready;
    reset = 1'b0;
    sel = 1'b0; we = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen |= ready; end
    reset = 1'b1;
    repeat (6) begin @(posedge clk); #1; seen |= ready; end
    check("mid_reset_no_ready", {31'd0, seen}, 32'd0);
    bus_read(32'h4, rd);
    check("mid_reset_status", rd, 32'h0000_000A);
    check("mid_reset_tx_valid", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic test_write_latency();
    tx_ready = 1'b0;
    bus_xfer(1'b1, 32'h0, 32'hA5, rd, lat);
    check("write_latency", lat, WAIT + 1);
    check("write_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("write_tx_data", {24'd0, tx_data}, 32'hA5);
    bus_read(32'h4, rd);
    check("write_status", rd, 32'h0000_0108);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("drain_tx_valid", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) bus_write(32'h0, 32'(i + 1));
    bus_read(32'h4, rd);
    check("ovf_status", rd, 32'h0000_0819);
    bus_write(32'h4, 32'h10);
    bus_read(32'h4, rd);
    check("ovf_w1c_status", rd, 32'h0000_0809);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("ovf_drain_data", {23'd0, tx_valid, tx_data}, 32'h100 | 32'(k));
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    check("ovf_drain_empty", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic test_rx_irq();
    bus_write(32'h8, 32'h1);
    rx_valid = 1'b1; rx_data = 8'h3C;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_set", {31'd0, irq}, 32'd1);
    bus_read(32'h0, rd);
    check("rx_read_data", rd, 32'h0000_003C);
    @(posedge clk); #1;
    check("irq_clear", {31'd0, irq}, 32'd0);
    bus_read(32'h0, rd);
    check("rx_underflow_data", rd, 32'd0);
    bus_read(32'h4, rd);
    check("rx_unf_status", rd, 32'h0000_002A);
    bus_write(32'h4, 32'h20);
    bus_write(32'h8, 32'h0);
    bus_read(32'h4, rd);
    check("rx_unf_cleared", rd, 32'h0000_000A);
  endtask

  task automatic test_simultaneous();
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'h40 + i);
      @(posedge clk); #1;
    end
    rx_data = 8'hEE;
    check("rx_full_ready", {31'd0, rx_ready}, 32'd0);
    bus_read(32'h0, rd);
    check("sim_pop_data", rd, 32'h40);
    check("sim_rx_ready_at_pop", {31'd0, rx_ready_at_resp}, 32'd0);
    bus_read(32'h4, rd);
    check("sim_status", rd, 32'h0007_0002);
    bus_write(32'h8, 32'h4);
    bus_read(32'h4, rd);
    check("rx_flush_status", rd, 32'h0000_000A);
    check("rx_flush_ready", {31'd0, rx_ready}, 32'd1);
    bus_read(32'h8, rd);
    check("ctrl_flush_selfclear", rd, 32'd0);
  endtask

`ifdef MBOX_LOOPBACK_EN
  task automatic test_loopback();
    logic any_tx;
    any_tx = 1'b0;
    bus_write(32'h8, 32'h8);
    bus_read(32'h8, rd);
    check("lb_ctrl_read", rd, 32'h8);
    bus_write(32'h0, 32'h11);
    any_tx |= tx_valid;
    bus_write(32'h0, 32'h22);
    any_tx |= tx_valid;
    bus_read(32'h0, rd);
    check("lb_first", rd, 32'h11);
    any_tx |= tx_valid;
    bus_read(32'h0, rd);
    check("lb_second", rd, 32'h22);
    check("lb_tx_valid_low", {31'd0, any_tx}, 32'd0);
    bus_write(32'h8, 32'h0);
  endtask
`else
  task automatic test_loopback();
    bus_write(32'h8, 32'h9);
    bus_read(32'h8, rd);
    check("no_lb_ctrl_read", rd, 32'h1);
    bus_write(32'h8, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_write_latency();
    test_overflow();
    test_rx_irq();
    test_simultaneous();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
